// File: rtl/vga_text_engine_if.sv
// Read bus between the VGA text engine and its character buffer / font ROM.
// Both memories return data one clock after the address changes.
interface vga_text_engine_if #(
    parameter int AW = 12
);
    logic [AW-1:0] char_addr;
    logic [7:0]    char_data;
    logic [11:0]   font_addr;
    logic [7:0]    font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_data,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_data,
        output font_data
    );
endinterface

// File: rtl/vga_text_engine.sv
// VGA text engine: 3-stage strobe-driven pipeline from raster counters to
// pixels, fetching characters and glyph rows from external memories.
module vga_text_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLS     = 80,
    parameter int ROWS     = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              mode,
    input  logic [23:0]       fg_color,
    input  logic [23:0]       bg_color,
    vga_text_engine_if.master mem,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              hsync,
    output logic              vsync,
    output logic              n_blank,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(COLS * ROWS);
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          mode_q;
    logic          h_end;
    logic          v_end;

    assign h_end = (h_cnt == HW'(H_TOTAL - 1));
    assign v_end = (v_cnt == VW'(V_TOTAL - 1));

    // Raster counters; the display mode only changes on the (0,0) wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= 1'b0;
        end else if (pix_en) begin
            if (h_end) begin
                h_cnt <= '0;
                if (v_end) begin
                    v_cnt  <= '0;
                    mode_q <= mode;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    logic          active_c;
    logic          hs_c;
    logic          vs_c;
    logic          grid_c;
    logic          first_c;
    logic [AW-1:0] addr_c;
    logic [2:0]    bar_c;

    always_comb begin
        active_c = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_c     = (int'(h_cnt) >= HS_LO) && (int'(h_cnt) < HS_HI);
        vs_c     = (int'(v_cnt) >= VS_LO) && (int'(v_cnt) < VS_HI);
        grid_c   = (int'(h_cnt) < COLS * 8) && (int'(v_cnt) < ROWS * 16);
        first_c  = (h_cnt == '0) && (v_cnt == '0);
        addr_c   = '0;
        if (grid_c) begin
            addr_c = AW'((int'(v_cnt) >> 4) * COLS + (int'(h_cnt) >> 3));
        end
        bar_c    = 3'(int'(h_cnt) / BAR_W);
    end

    logic [3:0] s1_row;
    logic [2:0] s1_px;
    logic [2:0] s1_bar;
    logic       s1_active;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_grid;
    logic       s1_first;
    logic       s1_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem.char_addr <= '0;
            s1_row        <= '0;
            s1_px         <= '0;
            s1_bar        <= '0;
            s1_active     <= 1'b0;
            s1_hs         <= 1'b0;
            s1_vs         <= 1'b0;
            s1_grid       <= 1'b0;
            s1_first      <= 1'b0;
            s1_mode       <= 1'b0;
        end else if (pix_en) begin
            mem.char_addr <= addr_c;
            s1_row        <= v_cnt[3:0];
            s1_px         <= h_cnt[2:0];
            s1_bar        <= bar_c;
            s1_active     <= active_c;
            s1_hs         <= hs_c;
            s1_vs         <= vs_c;
            s1_grid       <= grid_c;
            s1_first      <= first_c;
            s1_mode       <= mode_q;
        end
    end

    logic [2:0] s2_px;
    logic [2:0] s2_bar;
    logic       s2_active;
    logic       s2_hs;
    logic       s2_vs;
    logic       s2_grid;
    logic       s2_first;
    logic       s2_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem.font_addr <= '0;
            s2_px         <= '0;
            s2_bar        <= '0;
            s2_active     <= 1'b0;
            s2_hs         <= 1'b0;
            s2_vs         <= 1'b0;
            s2_grid       <= 1'b0;
            s2_first      <= 1'b0;
            s2_mode       <= 1'b0;
        end else if (pix_en) begin
            mem.font_addr <= {mem.char_data, s1_row};
            s2_px         <= s1_px;
            s2_bar        <= s1_bar;
            s2_active     <= s1_active;
            s2_hs         <= s1_hs;
            s2_vs         <= s1_vs;
            s2_grid       <= s1_grid;
            s2_first      <= s1_first;
            s2_mode       <= s1_mode;
        end
    end

    logic [23:0] rgb_c;

    // Bar order white..black maps each channel to an inverted index bit.
    always_comb begin
        rgb_c = '0;
        if (s2_active) begin
            if (s2_mode) begin
                rgb_c = {{8{~s2_bar[1]}}, {8{~s2_bar[2]}}, {8{~s2_bar[0]}}};
            end else if (s2_grid && mem.font_data[~s2_px]) begin
                rgb_c = fg_color;
            end else begin
                rgb_c = bg_color;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            n_blank     <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            red_out     <= rgb_c[23:16];
            green_out   <= rgb_c[15:8];
            blue_out    <= rgb_c[7:0];
            hsync       <= s2_hs ? HS_POL : ~HS_POL;
            vsync       <= s2_vs ? VS_POL : ~VS_POL;
            n_blank     <= s2_active;
            frame_start <= s2_first;
        end
    end

endmodule

// File: tb/tb_vga_text_engine.sv
// Bench for vga_text_engine: reduced raster, two grid sizes, scoreboard
// of expected pixels plus a table of fixed spot values.
module tb_vga_text_engine;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSW = 2, VBP = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int CA = 80, RA = 30, CB = 4, RB = 2;
  localparam int NS = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic mode = 1'b0;
  logic [23:0] fg = 24'hFFFFFF;
  logic [23:0] bg = 24'h000000;

  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic hsync_a, vsync_a, nb_a, fs_a;
  logic hsync_b, vsync_b, nb_b, fs_b;

  always #5 clock = ~clock;

  vga_text_engine_if #(.AW(12)) mem_a ();
  vga_text_engine_if #(.AW(3)) mem_b ();

  vga_text_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLS(CA), .ROWS(RA)
  ) dut_a (
    .clock(clock), .reset(reset), .pix_en(pix_en), .mode(mode),
    .fg_color(fg), .bg_color(bg), .mem(mem_a),
    .red_out(red_a), .green_out(green_a), .blue_out(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .n_blank(nb_a),
    .frame_start(fs_a)
  );

  vga_text_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLS(CB), .ROWS(RB)
  ) dut_b (
    .clock(clock), .reset(reset), .pix_en(pix_en), .mode(mode),
    .fg_color(fg), .bg_color(bg), .mem(mem_b),
    .red_out(red_b), .green_out(green_b), .blue_out(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .n_blank(nb_b),
    .frame_start(fs_b)
  );

  logic [7:0] cmem [4096];
  logic [7:0] from [4096];

  always @(posedge clock) begin
    mem_a.char_data <= cmem[mem_a.char_addr];
    mem_a.font_data <= from[mem_a.font_addr];
    mem_b.char_data <= cmem[{9'd0, mem_b.char_addr}];
    mem_b.font_data <= from[mem_b.font_addr];
  end

  typedef struct {
    int h; int v; int frame;
    logic nb; logic hs; logic vs; logic fs;
    int ka; int kb; logic [23:0] bar;
  } exp_t;

  typedef struct {
    int frame; int h; int v; logic [23:0] rgb; logic nb;
  } spot_t;

  exp_t q[$];
  exp_t lastexp;
  spot_t spots [NS];
  int total = 0;
  int bad = 0;
  int hits = 0;
  int mh, mv, mframe, ph, pv;
  logic mlat, pvalid, pnb;

  task automatic chk(string nm, int h, int v,
                     logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25)
        $display("FAIL %s h=%0d v=%0d got=%h want=%h",
                 nm, h, v, act, exp);
    end
  endtask

  function automatic int eaddr(int h, int v, int cols, int rows);
    if (h < cols * 8 && v < rows * 16) return (v / 16) * cols + h / 8;
    return 0;
  endfunction

  function automatic int kind(int h, int v, logic m, int cols, int rows);
    logic [7:0] code, bits;
    if (!(h < HA && v < VA)) return 0;
    if (m) return 3;
    if (h >= cols * 8 || v >= rows * 16) return 2;
    code = cmem[(v / 16) * cols + h / 8];
    bits = from[int'(code) * 16 + v % 16];
    return bits[7 - h % 8] ? 1 : 2;
  endfunction

  function automatic logic [23:0] barc(int h);
    case (h / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] col(int k, logic [23:0] bar);
    case (k)
      1: return fg;
      2: return bg;
      3: return bar;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t mk(int h, int v, int fr, logic m);
    exp_t e;
    e.h = h; e.v = v; e.frame = fr;
    e.nb = (h < HA) && (v < VA);
    e.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    e.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
    e.fs = (h == 0) && (v == 0);
    e.ka = kind(h, v, m, CA, RA);
    e.kb = kind(h, v, m, CB, RB);
    e.bar = barc(h);
    return e;
  endfunction

  function automatic exp_t mkrst();
    exp_t e;
    e.h = -1; e.v = -1; e.frame = -1;
    e.nb = 0; e.hs = 0; e.vs = 0; e.fs = 0;
    e.ka = 0; e.kb = 0; e.bar = 24'h0;
    return e;
  endfunction

  task automatic restart(int fr);
    q.delete();
    q.push_back(mkrst());
    q.push_back(mkrst());
    mh = 0; mv = 0; mlat = 1'b0; mframe = fr; pvalid = 1'b0;
  endtask

  task automatic check_reset(string nm);
    chk({nm, "_rgb_a"}, -1, -1, {red_a, green_a, blue_a}, 0);
    chk({nm, "_rgb_b"}, -1, -1, {red_b, green_b, blue_b}, 0);
    chk({nm, "_nb"}, -1, -1, {nb_a, nb_b}, 0);
    chk({nm, "_fs"}, -1, -1, {fs_a, fs_b}, 0);
    chk({nm, "_hs"}, -1, -1, {hsync_a, hsync_b}, 2'b10);
    chk({nm, "_vs"}, -1, -1, {vsync_a, vsync_b}, 2'b11);
    chk({nm, "_caddr"}, -1, -1, mem_a.char_addr, 0);
    chk({nm, "_faddr"}, -1, -1, mem_a.font_addr, 0);
  endtask

  task automatic step();
    exp_t e, o;
    logic [11:0] fa;
    e = mk(mh, mv, mframe, mlat);
    q.push_back(e);
    pix_en = 1'b1;
    @(negedge clock);
    pix_en = 1'b0;
    @(negedge clock);
    o = q.pop_front();
    lastexp = o;
    chk("rgb_a", o.h, o.v, {red_a, green_a, blue_a}, col(o.ka, o.bar));
    chk("nblank_a", o.h, o.v, nb_a, o.nb);
    chk("hsync_a", o.h, o.v, hsync_a, !o.hs);
    chk("vsync_a", o.h, o.v, vsync_a, !o.vs);
    chk("fstart_a", o.h, o.v, fs_a, o.fs);
    chk("rgb_b", o.h, o.v, {red_b, green_b, blue_b}, col(o.kb, o.bar));
    chk("nblank_b", o.h, o.v, nb_b, o.nb);
    chk("hsync_b", o.h, o.v, hsync_b, o.hs);
    chk("vsync_b", o.h, o.v, vsync_b, !o.vs);
    chk("fstart_b", o.h, o.v, fs_b, o.fs);
    for (int i = 0; i < NS; i++) begin
      if (spots[i].frame == o.frame && spots[i].h == o.h &&
          spots[i].v == o.v) begin
        hits++;
        chk("spot_rgb", o.h, o.v, {red_a, green_a, blue_a}, spots[i].rgb);
        chk("spot_nb", o.h, o.v, nb_a, spots[i].nb);
      end
    end
    if (e.nb) begin
      chk("caddr_a", mh, mv, mem_a.char_addr, eaddr(mh, mv, CA, RA));
      chk("caddr_b", mh, mv, mem_b.char_addr, eaddr(mh, mv, CB, RB));
    end
    if (pvalid && pnb) begin
      fa = {cmem[eaddr(ph, pv, CA, RA)], pv[3:0]};
      chk("faddr_a", ph, pv, mem_a.font_addr, fa);
      fa = {cmem[eaddr(ph, pv, CB, RB)], pv[3:0]};
      chk("faddr_b", ph, pv, mem_b.font_addr, fa);
    end
    ph = mh; pv = mv; pnb = e.nb; pvalid = 1'b1;
    if (mh == HT - 1) begin
      mh = 0;
      if (mv == VT - 1) begin
        mv = 0;
        mframe++;
        mlat = mode;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  initial begin
    int n, found;
    logic hit;
    for (int i = 0; i < 4096; i++) begin
      cmem[i] = 8'(i * 7 + 3);
      from[i] = 8'((i * 29) ^ (i >> 3));
    end
    cmem[81] = 8'h41;
    from[{8'h41, 4'd3}] = 8'b1000_0001;
    from[{8'h41, 4'd9}] = 8'hFF;

    spots[0]  = '{0, 8, 19, 24'hFFFFFF, 1'b1};
    spots[1]  = '{0, 9, 19, 24'h000000, 1'b1};
    spots[2]  = '{0, 14, 19, 24'h000000, 1'b1};
    spots[3]  = '{0, 15, 19, 24'hFFFFFF, 1'b1};
    spots[4]  = '{0, 8, 25, 24'hFFFFFF, 1'b1};
    spots[5]  = '{0, 64, 19, 24'h000000, 1'b0};
    spots[6]  = '{1, 0, 5, 24'hFFFFFF, 1'b1};
    spots[7]  = '{1, 7, 5, 24'hFFFFFF, 1'b1};
    spots[8]  = '{1, 8, 5, 24'hFFFF00, 1'b1};
    spots[9]  = '{1, 16, 5, 24'h00FFFF, 1'b1};
    spots[10] = '{1, 24, 5, 24'h00FF00, 1'b1};
    spots[11] = '{1, 32, 5, 24'hFF00FF, 1'b1};
    spots[12] = '{1, 40, 5, 24'hFF0000, 1'b1};
    spots[13] = '{1, 48, 5, 24'h0000FF, 1'b1};
    spots[14] = '{1, 56, 5, 24'h000000, 1'b1};
    spots[15] = '{1, 63, 39, 24'h000000, 1'b1};
    spots[16] = '{2, 8, 19, 24'hA5C3E1, 1'b1};
    spots[17] = '{2, 9, 19, 24'h123456, 1'b1};
    spots[18] = '{10, 8, 19, 24'hA5C3E1, 1'b1};
    spots[19] = '{10, 9, 19, 24'h123456, 1'b1};

    repeat (3) @(negedge clock);
    check_reset("por");
    reset = 1'b0;
    restart(0);

    hit = 1'b0;
    for (int s = 0; s < 3 * HT * VT; s++) begin
      if (mframe == 2 && mv == 30 && mh == 20) begin
        hit = 1'b1;
        break;
      end
      if (mframe == 0 && mv == 20 && mh == 0) mode = 1'b1;
      if (mframe == 1 && mv == 5 && mh == 0) mode = 1'b0;
      if (mframe == 2 && mv == 0 && mh == 0) begin
        fg = 24'hA5C3E1;
        bg = 24'h123456;
      end
      if (mframe == 0 && mv == 10 && mh == 30) begin
        repeat (7) @(negedge clock);
        chk("freeze_rgb", lastexp.h, lastexp.v, {red_a, green_a, blue_a},
            col(lastexp.ka, lastexp.bar));
        chk("freeze_nb", lastexp.h, lastexp.v, nb_a, lastexp.nb);
        chk("freeze_fs", lastexp.h, lastexp.v, fs_a, lastexp.fs);
      end
      step();
    end

    if (hit) begin
      reset = 1'b1;
      #1;
      check_reset("midrst");
      @(negedge clock);
      repeat (2) begin
        pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0;
        @(negedge clock);
      end
      check_reset("rsthold");
      reset = 1'b0;
      restart(10);
      for (int s = 0; s < HT * VT + 4; s++) step();
    end else begin
      chk("midrst_point", mh, mv, 0, 1);
    end
    chk("spot_hits", -1, -1, hits, NS);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pix_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("fs_first", k, 0, fs_a, (k == 3));
    end
    n = 3;
    found = -1;
    for (int k = 0; k < HT * VT + 10; k++) begin
      @(negedge clock);
      n++;
      if (fs_a) begin
        found = n;
        break;
      end
    end
    chk("fs_period", -1, -1, found, 3 + HT * VT);
    @(negedge clock);
    chk("fs_width", -1, -1, fs_a, 0);
    pix_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_engine.md
VGA_TEXT_ENGINE -- requirements
Module: vga_text_engine

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch/sync widths in pixels; H_TOTAL = sum of the four.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical equivalents in lines; V_TOTAL = sum of the four.
REQ-004 Parameters HS_POL/VS_POL, 0/0, active sync level (0 = active-low).
REQ-005 Parameters COLS/ROWS, 80/30, text grid size in 8x16 glyph cells; AW = clog2(COLS*ROWS).
REQ-006 clock  in  1  system clock (clock_50 domain).
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pix_en  in  1  pixel strobe; the pipeline advances only on cycles with pix_en=1 (one in two clocks for 25 MHz).
REQ-009 mode  in  1  0 = text, 1 = colour-bar test pattern.
REQ-010 fg_color, bg_color  in  24 each  {R,G,B} glyph and background colours.
REQ-011 char_addr  out  AW  character buffer read address, row*COLS+col.
REQ-012 char_data  in  8  character code; valid one clock after char_addr changes.
REQ-013 font_addr  out  12  {char_code, glyph_row[3:0]}.
REQ-014 font_data  in  8  glyph row bits, MSB = leftmost pixel; valid one clock after font_addr changes.
REQ-015 red_out, green_out, blue_out  out  8 each  pixel colour.
REQ-016 hsync, vsync, n_blank  out  1 each  VGA timing; n_blank high in the active area.
REQ-017 frame_start  out  1  one-pix_en-period pulse aligned with output of pixel (0,0).

Function
REQ-018 h_cnt counts 0..H_TOTAL-1 on pix_en; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps 0 after V_TOTAL-1.
REQ-019 Active area is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule vertically.
REQ-020 Stage 1 (pix_en): register char_addr = (v_cnt>>4)*COLS + (h_cnt>>3); register glyph_row = v_cnt[3:0], px = h_cnt[2:0], active, sync and in_grid flags.
REQ-021 Stage 2 (pix_en): register font_addr = {char_data, glyph_row}; forward px and flags.
REQ-022 Stage 3 (pix_en): register the output colour = fg_color if font_data[7-px]=1, else bg_color; register hsync, vsync, n_blank and frame_start.
REQ-023 Latency: counter state to pins is exactly 3 pix_en strobes for colour, syncs, n_blank and frame_start alike.
REQ-024 char_addr and font_addr hold stable between strobes, so 1-clock memory data is valid at the next strobe.
REQ-025 Active pixels outside the grid (h >= COLS*8 or v >= ROWS*16) output bg_color, and their char_addr is forced to 0.
REQ-026 Blanked pixels output RGB = 0 in both modes.
REQ-027 Mode 1: eight bars, each H_ACTIVE/8 wide, coloured left to right white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF/8'h00).
REQ-028 mode is latched only when the counters wrap to (0,0); a change mid-frame takes effect at the next frame.
REQ-029 pix_en=0 freezes all state and outputs.

Reset
REQ-030 While reset=1, all of the following hold:
- h_cnt, v_cnt, char_addr, font_addr = 0
- RGB = 0, n_blank = 0, frame_start = 0
- hsync = ~HS_POL, vsync = ~VS_POL
- latched mode = 0
REQ-031 Reset asserted mid-frame takes effect immediately; after release, the first output pixel (0,0) with frame_start=1 appears on the 3rd pix_en strobe.

Verification
REQ-032 Reset release with pix_en=1 every cycle -> frame_start high on strobe 3, then every 420000 strobes (800*525).
REQ-033 Default parameters, measured at the pins -> per line: hsync low for 96 strobes starting 656 after n_blank rises, n_blank high 640 strobes; per frame: vsync low for 2 lines starting at line 490.
REQ-034 Text mode; char memory addr 81 = 8'h41; font ROM {8'h41,4'd3} = 8'b1000_0001; fg=24'hFFFFFF; bg=24'h000000 -> line 19, pixels 8 and 15 are white, pixels 9-14 are black; char_addr=81 observed for that cell.
REQ-035 COLS=40, ROWS=20 -> pixels h>=320 or v>=320 in the active area show bg_color.
REQ-036 mode toggled 0->1 at line 100 -> the current frame stays text; the next frame shows bars with the boundary at pixel 80 (white to yellow).
REQ-037 reset pulsed at line 200 -> outputs immediately take reset values; the timing restarts from (0,0).
